keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 16: clock cycles each column is driven during scanning; legal values are 4 and above.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000: consecutive stable cycles required to accept a press or a release; legal values are 2 and above.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 row_in  input  4  asynchronous keypad row lines, active-low, externally pulled up.
REQ-006 col_out  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  code of last accepted key; feeds the calculator control key input.
REQ-008 key_valid  output  1  one-cycle pulse, asserted in the cycle key_code is updated.
REQ-009 key_held  output  1  high while an accepted key remains pressed (until release is debounced).

Function
REQ-010 row_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rs[3:0].
REQ-011 Key code SHALL be {row_index[1:0], col_index[1:0]}: 0-9 digits, 4'hA add, 4'hB sub, 4'hC store, 4'hD load, 4'hE enter, 4'hF spare.
REQ-012 The FSM SHALL have the states SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-013 SCAN: col_out SHALL drive column c low for SCAN_CYCLES cycles, then advance c to (c+1) mod 4 (column 3 wraps to 0).
REQ-014 SCAN: rs SHALL be ignored for the first 2 cycles of each column dwell (settle window).
REQ-015 SCAN, outside the settle window: if exactly one bit of rs is low, the FSM SHALL latch the row and column, freeze the column, clear the counter and go to DEBOUNCE.
REQ-016 SCAN: rs all high, or two or more rows low (ghost or multi-key), SHALL be ignored and scanning SHALL continue.
REQ-017 DEBOUNCE: the counter SHALL increment each cycle rs equals the latched pattern; any other rs value SHALL abort to SCAN, resume at the next column, and produce no pulse.
REQ-018 DEBOUNCE: when the counter reaches DEBOUNCE_CYCLES-1 with a matching rs, on the next edge key_code SHALL take the key code, key_valid SHALL pulse for 1 cycle, key_held SHALL go 1, and the FSM SHALL go to PRESSED.
REQ-019 PRESSED: the column SHALL stay frozen; when rs is all high, the counter SHALL clear and the FSM SHALL go to RELEASE.
REQ-020 PRESSED: a change to a different non-idle row pattern SHALL be ignored (no new key until release).
REQ-021 RELEASE: the counter SHALL increment on each all-high cycle; any low row SHALL return the FSM to PRESSED with no key_valid.
REQ-022 RELEASE: after DEBOUNCE_CYCLES consecutive all-high cycles, key_held SHALL go 0 and the FSM SHALL go to SCAN at the next column.
REQ-023 key_code SHALL hold its value until the next accepted key, including through release.
REQ-024 key_valid SHALL never be high for 2 consecutive cycles; each physical press SHALL produce at most one pulse.
REQ-025 Latency from a stable press entering DEBOUNCE to the key_valid pulse SHALL be DEBOUNCE_CYCLES+1 cycles.
REQ-026 The counter SHALL be sized ceil(log2(max(SCAN_CYCLES, DEBOUNCE_CYCLES)))+1 bits and SHALL never wrap.

Reset
REQ-027 While reset is high at a clock edge: state=SCAN, column index=0, col_out=4'b1110, key_code=4'h0, key_valid=0, key_held=0, counter=0, synchronizer=4'hF.
REQ-028 Reset asserted in any state, including mid-debounce or mid-press, SHALL take effect at that edge with no key_valid pulse; a key still held after reset SHALL be re-detected via SCAN and debounce.

Verification
(Bench parameters: SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.)
REQ-029 Hold row 2 low whenever column 1 is driven, stable for 20 cycles -> exactly one key_valid pulse, key_code=4'h9, key_held=1; release -> key_held=0 after 8 idle cycles.
REQ-030 Press row 3 / column 2 with a 3-cycle glitch before a stable press -> no pulse on the glitch; a single pulse later with key_code=4'hE.
REQ-031 Rows 0 and 1 both low on column 0 -> no key_valid, col_out keeps cycling 1110, 1101, 1011, 0111, 1110.
REQ-032 Accepted key 4'h5, then a release bounce (rows high 3 cycles, low 2, high 8+) -> no second pulse; key_held stays 1 through the bounce, then drops.
REQ-033 Reset asserted 5 cycles into DEBOUNCE -> next edge col_out=4'b1110, key_valid=0, key_code=4'h0; a key still held is re-accepted with one pulse.
REQ-034 Key 4'hA pressed and released, then key 4'h3 -> two pulses separated by at least 17 cycles; key_code=4'hA between them, then 4'h3.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low keypad one column at a time, debounces a single
//   pressed key, reports it once, and then waits for a debounced release.
//
// Ports
//   clk       in   rising-edge clock for all state
//   reset     in   synchronous, active-high reset
//   row_in    in   [3:0] asynchronous row lines, active-low, pulled up
//   col_out   out  [3:0] column drive, active-low, exactly one bit low
//   key_code  out  [3:0] {row_index, col_index} of the last accepted key
//   key_valid out  one-cycle pulse in the cycle key_code is updated
//   key_held  out  high from acceptance until the release is debounced
//
// Handshake: key_valid is a qualifier only -- there is no ready. key_code is
// new in exactly the cycle key_valid is high and then holds its value until
// the next accepted key; a consumer that misses the pulse loses that key.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  // First dwell cycles in which rs may still reflect the previous column.
  localparam logic [CW-1:0] SETTLE    = CW'(2);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    col;
  logic [1:0]    row_lat;
  logic [3:0]    pat;
  logic [CW-1:0] cnt;
  logic [3:0]    s1;
  logic [3:0]    rs;

  // Row decode of the synchronized lines: valid only when exactly one is low.
  logic [3:0] low;
  logic       single_low;
  logic [1:0] row_idx;

  always_comb begin
    low        = ~rs;
    single_low = (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
    row_idx    = 2'd0;
    case (low)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      col_out   <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      cnt       <= '0;
      row_lat   <= 2'd0;
      pat       <= 4'hF;
      s1        <= 4'hF;
      rs        <= 4'hF;
    end else begin
      s1        <= row_in;
      rs        <= s1;
      key_valid <= 1'b0;

      case (state)
        SCAN: begin
          // A detection on the last dwell cycle wins over the column advance,
          // so the column stays frozen on the key that was seen.
          if (cnt >= SETTLE && single_low) begin
            row_lat <= row_idx;
            pat     <= rs;
            cnt     <= '0;
            state   <= DEBOUNCE;
          end else if (cnt == SCAN_LAST) begin
            cnt     <= '0;
            col     <= col + 2'd1;
            col_out <= col_drive(col + 2'd1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (rs == pat) begin
            if (cnt == DB_LAST) begin
              key_code  <= {row_lat, col};
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              cnt       <= '0;
              state     <= PRESSED;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            // Bounce or a second key: give up and move on to the next column.
            cnt     <= '0;
            col     <= col + 2'd1;
            col_out <= col_drive(col + 2'd1);
            state   <= SCAN;
          end
        end

        PRESSED: begin
          // Any non-idle pattern, even a different row, is just "still held".
          if (rs == 4'hF) begin
            cnt   <= '0;
            state <= RELEASE;
          end
        end

        RELEASE: begin
          if (rs == 4'hF) begin
            if (cnt == DB_LAST) begin
              key_held <= 1'b0;
              cnt      <= '0;
              col      <= col + 2'd1;
              col_out  <= col_drive(col + 2'd1);
              state    <= SCAN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= PRESSED;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.
//   A behavioural keypad drives row_in from col_out and a set of pressed
//   keys; every accepted key code is queued when the press is staged and
//   popped when key_valid pulses.
module tb_keypad_scanner;

  localparam int SCAN_CYCLES     = 4;
  localparam int DEBOUNCE_CYCLES = 8;

  logic       clk;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;          // bit row*4+col set while that key is pressed
  logic [3:0]  exp_q[$];
  int          vectors;
  int          miscompares;
  int          cyc;
  logic        prev_valid;

  keypad_scanner #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- keypad model ----------------
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every pulse must match the oldest staged key.
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      check("no_back_to_back", {31'd0, prev_valid & key_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {31'd0, key_valid}, 32'd0);
      end else begin
        check("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
      end
    end
    prev_valid <= key_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!key_valid && n < budget);
    check(tag, {31'd0, key_valid}, 32'd1);
  endtask

  task automatic wait_held_low(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (key_held && n < budget);
    check(tag, {31'd0, key_held}, 32'd0);
  endtask

  // Returns at the negedge right after col_out switches to the given drive.
  task automatic wait_col_start(input logic [3:0] drive, input int budget);
    int n;
    n = 0;
    while (col_out == drive && n < budget) begin
      @(negedge clk);
      n++;
    end
    while (col_out != drive && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("col_reached", {28'd0, col_out}, {28'd0, drive});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_first;
    int changes;
    logic [3:0] prev_col;

    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    prev_valid  = 1'b0;
    keys        = 16'h0;
    reset       = 1'b1;

    // Reset state
    cycles(3);
    check("rst_col_out", {28'd0, col_out}, 32'he);
    check("rst_key_code", {28'd0, key_code}, 32'h0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_held", {31'd0, key_held}, 32'd0);
    reset = 1'b0;

    // Key 9: row 2 / column 1, held well past acceptance
    keys = 16'h0200;
    exp_q.push_back(4'h9);
    wait_valid("k9_pulse", 60);
    cycles(1);
    check("k9_held", {31'd0, key_held}, 32'd1);
    check("k9_code_hold", {28'd0, key_code}, 32'h9);
    cycles(20);
    keys = 16'h0;
    cycles(DEBOUNCE_CYCLES);
    check("k9_held_thru_release", {31'd0, key_held}, 32'd1);
    wait_held_low("k9_release", 20);

    // Key E: 3-cycle glitch on column 2, then a stable press
    wait_col_start(4'b1011, 60);
    keys = 16'h4000;
    cycles(3);
    keys = 16'h0;
    cycles(20);
    check("glitch_no_held", {31'd0, key_held}, 32'd0);
    keys = 16'h4000;
    exp_q.push_back(4'hE);
    wait_valid("kE_pulse", 60);
    keys = 16'h0;
    wait_held_low("kE_release", 40);

    // Ghost: rows 0 and 1 low on column 0; scanning must keep rotating
    keys = 16'h0011;
    changes = 0;
    @(negedge clk);
    prev_col = col_out;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (col_out != prev_col) begin
        check("ghost_rotate", {28'd0, col_out}, {28'd0, prev_col[2:0], prev_col[3]});
        changes++;
      end
      prev_col = col_out;
    end
    check("ghost_col_steps", changes, 6);
    check("ghost_no_held", {31'd0, key_held}, 32'd0);
    keys = 16'h0;
    cycles(4);

    // Key 5 with a release bounce: high 3, low 2, then high
    keys = 16'h0020;
    exp_q.push_back(4'h5);
    wait_valid("k5_pulse", 60);
    cycles(4);
    keys = 16'h0;
    cycles(3);
    keys = 16'h0020;
    cycles(2);
    keys = 16'h0;
    cycles(2);
    check("k5_held_thru_bounce", {31'd0, key_held}, 32'd1);
    cycles(3);
    check("k5_held_mid_release", {31'd0, key_held}, 32'd1);
    wait_held_low("k5_release", 20);
    check("k5_code_after_release", {28'd0, key_code}, 32'h5);

    // Reset five cycles into debounce of key 6 (row 1 / column 2)
    wait_col_start(4'b1011, 60);
    keys = 16'h0040;
    cycles(7);
    reset = 1'b1;
    cycles(1);
    check("mid_rst_col_out", {28'd0, col_out}, 32'he);
    check("mid_rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("mid_rst_key_code", {28'd0, key_code}, 32'h0);
    reset = 1'b0;
    exp_q.push_back(4'h6);
    wait_valid("k6_reaccept", 60);
    keys = 16'h0;
    wait_held_low("k6_release", 40);

    // Key A then key 3
    keys = 16'h0400;
    exp_q.push_back(4'hA);
    wait_valid("kA_pulse", 60);
    t_first = cyc;
    keys = 16'h0;
    wait_held_low("kA_release", 40);
    check("kA_code_between", {28'd0, key_code}, 32'hA);
    keys = 16'h0008;
    exp_q.push_back(4'h3);
    wait_valid("k3_pulse", 60);
    check("pulse_gap_ok", {31'd0, (cyc - t_first) >= 17}, 32'd1);
    keys = 16'h0;
    wait_held_low("k3_release", 40);
    check("k3_code_final", {28'd0, key_code}, 32'h3);

    cycles(4);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
